// File: rtl/dmem_access_unit.sv
// dmem_access_unit: load/store initiator with extension, sub-word read-modify-write and error flagging.
module dmem_access_unit #(
  parameter int DEPTH      = 1024,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_uns,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_w_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);
  typedef enum logic [2:0] {IDLE, LD, ST_RD, ST_WR, ERR, RSP} state_t;
  state_t      state_q, state_d;
  logic [1:0]  size_q;
  logic        uns_q, err_q, err_in, accept;
  logic [31:0] addr_q, wdata_q, merge_q, merge_d, rdata_q, rdata_d, lmask;
  logic [4:0]  sh;
  logic [15:0] lane_v;
  assign accept = req_valid && state_q == IDLE;
  assign err_in = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && |req_addr[1:0]) || {2'b00, req_addr[31:2]} >= 32'(DEPTH);
  // Bit offset of the addressed lane inside the memory word
  assign sh = size_q == 2'b00 ? {(BIG_ENDIAN ? ~addr_q[1:0] : addr_q[1:0]), 3'b000}
                              : {(BIG_ENDIAN ? ~addr_q[1] : addr_q[1]), 4'b0000};
  assign lane_v  = 16'(mem_rd >> sh);
  assign lmask   = size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF;
  assign merge_d = (mem_rd & ~(lmask << sh)) | ((wdata_q & lmask) << sh);
  assign rdata_d = size_q == 2'b00 ? {{24{~uns_q & lane_v[7]}}, lane_v[7:0]}
                 : size_q == 2'b01 ? {{16{~uns_q & lane_v[15]}}, lane_v}
                 : mem_rd;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:          if (req_valid) state_d = err_in ? ERR : !req_we ? LD : req_size == 2'b10 ? ST_WR : ST_RD;
      LD, ST_WR, ERR: state_d = RSP;
      ST_RD:         state_d = ST_WR;
      default:       state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      size_q  <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        size_q  <= req_size;
        uns_q   <= req_uns;
        err_q   <= err_in;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        rdata_q <= '0;
      end
      if (state_q == LD) rdata_q <= rdata_d;
      if (state_q == ST_RD) merge_q <= merge_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RSP;
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid ? rdata_q : '0;
  // A reset arriving in ST_WR must suppress the write in that same cycle
  assign mem_w_en  = state_q == ST_WR && !rst;
  assign mem_addr  = state_q == IDLE ? '0 : {2'b00, addr_q[31:2]};
  assign mem_wd    = state_q == ST_WR ? (size_q == 2'b10 ? wdata_q : merge_q) : '0;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench with a word memory model around dmem_access_unit.
module tb_dmem_access_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_uns = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_err, mem_w_en;
  logic [31:0] rsp_rdata, mem_addr, mem_wd, mem_rd;
  logic [31:0] mem [0:1023];
  logic [32:0] sb_q [$];
  int          n_cmp = 0, n_bad = 0, wr_cnt = 0;

  dmem_access_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_uns(req_uns), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_w_en(mem_w_en),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;
  assign mem_rd = mem[mem_addr[9:0]];
  always @(posedge clk) if (mem_w_en) begin
    mem[mem_addr[9:0]] <= mem_wd;
    wr_cnt++;
  end

  always @(negedge clk) if (rsp_valid) begin
    logic [32:0] e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL rsp_unexpected: got err=%b rdata=%h, want no response", rsp_err, rsp_rdata);
    end else begin
      e = sb_q.pop_front();
      if ({rsp_err, rsp_rdata} !== e) begin
        n_bad++;
        $display("FAIL rsp_data: got err=%b rdata=%h, want err=%b rdata=%h", rsp_err, rsp_rdata, e[32], e[31:0]);
      end
    end
  end

  task automatic issue(input logic we, input logic [1:0] sz, input logic uns, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] erd, input logic eerr, input int lat, input int ewk);
    int k = 0, wk = 0, nw = 0;
    logic [31:0] wa = '0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ready_idle: got %b want 1", req_ready); end
    req_valid = 1'b1; req_we = we; req_size = sz; req_uns = uns; req_addr = a; req_wdata = wd;
    sb_q.push_back({eerr, erd});
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (k < 10) begin
      @(negedge clk);
      k++;
      if (mem_w_en) begin nw++; wk = k; wa = mem_addr; end
      if (rsp_valid) break;
    end
    n_cmp++;
    if (k !== lat) begin n_bad++; $display("FAIL latency a=%h: got %0d want %0d", a, k, lat); end
    n_cmp++;
    if (nw !== (ewk != 0 ? 1 : 0)) begin n_bad++; $display("FAIL write_count a=%h: got %0d want %0d", a, nw, ewk != 0 ? 1 : 0); end
    if (ewk != 0) begin
      n_cmp++;
      if (wk !== ewk || wa !== {2'b00, a[31:2]}) begin
        n_bad++; $display("FAIL write_when a=%h: got cyc %0d idx %h want cyc %0d idx %h", a, wk, wa, ewk, {2'b00, a[31:2]});
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, mem_w_en} !== 4'b1000 || rsp_rdata !== 0 || mem_addr !== 0 || mem_wd !== 0) begin
      n_bad++;
      $display("FAIL reset_state: got rdy=%b v=%b e=%b we=%b rd=%h ma=%h wd=%h want 1 0 0 0 0 0 0",
               req_ready, rsp_valid, rsp_err, mem_w_en, rsp_rdata, mem_addr, mem_wd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_loads();
    mem[5] = 32'h8081_7F01;
    issue(0, 2'b00, 0, 32'h14, 0, 32'hFFFF_FF80, 0, 2, 0);
    issue(0, 2'b00, 1, 32'h15, 0, 32'h0000_0081, 0, 2, 0);
    issue(0, 2'b01, 0, 32'h16, 0, 32'h0000_7F01, 0, 2, 0);
    issue(0, 2'b01, 0, 32'h14, 0, 32'hFFFF_8081, 0, 2, 0);
    issue(0, 2'b01, 1, 32'h14, 0, 32'h0000_8081, 0, 2, 0);
    issue(0, 2'b00, 0, 32'h17, 0, 32'h0000_0001, 0, 2, 0);
  endtask

  task automatic test_sub_store();
    mem[5] = 32'h1122_3344;
    issue(1, 2'b00, 0, 32'h16, 32'hFFFF_FFAA, 0, 0, 3, 2);
    n_cmp++;
    if (mem[5] !== 32'h1122_AA44) begin n_bad++; $display("FAIL sb_merge: got %h want 1122aa44", mem[5]); end
    issue(1, 2'b01, 0, 32'h14, 32'h5555_BEEF, 0, 0, 3, 2);
    n_cmp++;
    if (mem[5] !== 32'hBEEF_AA44) begin n_bad++; $display("FAIL sh_merge: got %h want beefaa44", mem[5]); end
  endtask

  task automatic test_word_store();
    issue(1, 2'b10, 0, 32'h20, 32'hDEAD_BEEF, 0, 0, 2, 1);
    n_cmp++;
    if (mem[8] !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL sw_mem: got %h want deadbeef", mem[8]); end
    issue(0, 2'b10, 0, 32'h20, 0, 32'hDEAD_BEEF, 0, 2, 0);
  endtask

  task automatic test_errors();
    int w0 = wr_cnt;
    issue(0, 2'b01, 0, 32'h13, 0, 0, 1, 2, 0);
    issue(1, 2'b10, 0, 32'h22, 32'h1234_5678, 0, 1, 2, 0);
    issue(0, 2'b11, 0, 32'h14, 0, 0, 1, 2, 0);
    issue(0, 2'b10, 0, 32'h1000, 0, 0, 1, 2, 0);
    issue(1, 2'b00, 0, 32'h1001, 32'h77, 0, 1, 2, 0);
    n_cmp++;
    if (wr_cnt !== w0) begin n_bad++; $display("FAIL err_no_write: got %0d writes want 0", wr_cnt - w0); end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    mem[4] = 32'hCAFE_F00D;
    w0 = wr_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b01; req_uns = 1'b0; req_addr = 32'h10; req_wdata = 32'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (mem_w_en !== 1'b0) begin n_bad++; $display("FAIL rst_wen: got %b want 0", mem_w_en); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_idle: got rdy=%b v=%b want 1 0", req_ready, rsp_valid);
    end
    n_cmp++;
    if (mem[4] !== 32'hCAFE_F00D || wr_cnt !== w0) begin
      n_bad++; $display("FAIL rst_nowrite: got %h writes %0d want cafef00d 0", mem[4], wr_cnt - w0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [3] = '{32'h14, 32'h20, 32'h23};
    logic [1:0]  szs   [3] = '{2'b10, 2'b00, 2'b00};
    logic        unss  [3] = '{1'b0, 1'b0, 1'b1};
    logic [31:0] exps  [3] = '{32'hBEEF_AA44, 32'hFFFF_FFDE, 32'h0000_00EF};
    int acc [3] = '{-1, -1, -1};
    int n = 0, busy = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_size = szs[0]; req_uns = unss[0]; req_addr = addrs[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (n < 3 && req_ready) begin
        acc[n] = c;
        sb_q.push_back({1'b0, exps[n]});
        n++;
      end else if (!req_ready) busy++;
      @(posedge clk); #1;
      if (n < 3) begin req_size = szs[n]; req_uns = unss[n]; req_addr = addrs[n]; end
      else req_valid = 1'b0;
    end
    n_cmp++;
    if (acc[0] !== 0 || acc[1] !== 3 || acc[2] !== 6) begin
      n_bad++; $display("FAIL b2b_spacing: got %0d %0d %0d want 0 3 6", acc[0], acc[1], acc[2]);
    end
    n_cmp++;
    if (busy !== 6) begin n_bad++; $display("FAIL b2b_ready_low: got %0d busy cycles want 6", busy); end
    n_cmp++;
    if (sb_q.size() !== 0) begin n_bad++; $display("FAIL b2b_pending: got %0d outstanding want 0", sb_q.size()); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    test_reset();
    test_loads();
    test_sub_store();
    test_word_store();
    test_errors();
    test_reset_mid_write();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
